seg7_serial_tx: RTL

- Transmit end of the 8-channel display path: takes the selected 32-bit display word, decimal-point mask and blank mask, and builds a 64-bit seven-segment frame.
- Shifts the frame serially into the board's cascaded 74HC595-style shift registers, then strobes their output latch.
- Sits between the channel multiplexer output and the on-board 8-digit display pins.

---
 rtl/seg7_serial_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_serial_tx.sv
// Seven-segment frame builder and 74HC595-style serial transmitter.
// Optional SEG_AUTO_REFRESH_EN: resend a frame after REFRESH_CYC idle cycles.
module seg7_serial_tx #(
  parameter int CLK_DIV = 2
`ifdef SEG_AUTO_REFRESH_EN
  , parameter int REFRESH_CYC = 1000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE_in,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_dout,
  output logic        seg_clrn,
  output logic        seg_latch
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [63:0] frame;
  logic [63:0] frame_d;
  logic [5:0]  idx;
  logic [7:0]  cnt;
  logic        go;

  // Active-low byte {dp, g..a}; blanking also kills the dp.
  function automatic logic [7:0] seg_byte(
    input logic [3:0] nib,
    input logic       dp,
    input logic       blank
  );
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    seg_byte = blank ? 8'hFF : {~dp, ~s};
  endfunction

  always_comb begin
    frame_d = '0;
    for (int i = 0; i < 8; i++) begin
      frame_d[8*i +: 8] = seg_byte(
        Disp_num[4*i +: 4], point_in[i], LE_in[i]);
    end
  end

`ifdef SEG_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYC + 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC);

  logic [RW-1:0] idle_cnt;

  // Held at zero outside IDLE so every IDLE visit counts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state != IDLE) begin
      idle_cnt <= '0;
    end else if (idle_cnt != REF_LAST) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign go = start || (idle_cnt == REF_LAST);
`else
  assign go = start;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frame     <= '0;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_dout  <= 1'b0;
      seg_clrn  <= 1'b0;
      seg_latch <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
      unique case (state)
        IDLE: begin
          if (seg_clrn && go) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          frame    <= frame_d;
          idx      <= 6'd63;
          cnt      <= '0;
          seg_clk  <= 1'b0;
          seg_dout <= frame_d[63];
          state    <= SHIFT;
        end
        SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= '0;
            if (!seg_clk) begin
              seg_clk <= 1'b1;
            end else begin
              seg_clk <= 1'b0;
              if (idx == 6'd0) begin
                seg_latch <= 1'b1;
                state     <= LATCH;
              end else begin
                idx      <= idx - 6'd1;
                seg_dout <= frame[idx - 6'd1];
              end
            end
          end
        end
        LATCH: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt       <= '0;
            seg_latch <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
